sub_serial: RTL
===============

Name: sub_serial

Overview:
Bit-serial two's-complement subtractor that computes out = a - b, one bit per clock, LSB first. It is the inverse-operation companion to the serial adder in the arithmetic datapath and uses the same level-enable start/done handshake, so the two are interchangeable behind a common controller. Operands are loaded in parallel and the result is delivered in parallel together with a borrow flag.

Parameters:
WIDTH, 8, operand and result width in bits (minimum 2).
CNT_W, 3, width of the bit counter; must satisfy 2^CNT_W >= WIDTH.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  reset, asynchronous, active-high.
en  input  1  start / hold request, level-sensitive.
a  input  WIDTH  minuend, sampled only on the start edge.
b  input  WIDTH  subtrahend, sampled only on the start edge.
out  output  WIDTH  difference a - b mod 2^WIDTH, registered.
borrow  output  1  final borrow (1 when a < b unsigned), registered.
busy  output  1  high while in SUB.
done  output  1  high while in DONE.

Behaviour:
- Internal registers: state (IDLE/SUB/DONE), a_reg, b_reg, count, brw. Outputs out and borrow are registers; busy and done decode directly from state.
- Reset (async, any time, including mid-operation): state = IDLE; out, a_reg, b_reg, count, brw, and borrow all 0. busy = 0, done = 0.
- IDLE state:
  - If en = 1 at a rising edge: a_reg <= a, b_reg <= b, out <= 0, count <= 0, brw <= 0, borrow <= 0, and state moves to SUB.
  - If en = 0: all registers hold. out and borrow keep the previous result.
- SUB state (one bit per cycle):
  - d = a_reg[0] ^ b_reg[0] ^ brw.
  - brw <= (~a_reg[0] & b_reg[0]) | (~a_reg[0] & brw) | (b_reg[0] & brw).
  - out <= {d, out[WIDTH-1:1]}.
  - a_reg >>= 1, b_reg >>= 1 (zero fill), count <= count + 1.
  - en is ignored throughout SUB; the operation cannot be aborted except by rst.
  - When count == WIDTH-1 at the edge: perform the final bit step, set borrow <= next brw, and move to DONE.
- DONE state:
  - out and borrow hold; done = 1.
  - If en = 1: stay in DONE. No restart happens while en is still held.
  - If en = 0: return to IDLE.
  - A new operation therefore requires en to go low for at least one cycle and then high again.
- Latency: if en is sampled high at edge E0, SUB occupies edges E1..E_WIDTH. done and valid out/borrow are visible after edge E_WIDTH, i.e. WIDTH+1 edges after start.
- Arithmetic: result is modulo 2^WIDTH. borrow equals the unsigned a < b comparison. When a == b: out = 0, borrow = 0.
- Simultaneous events: rst dominates all other inputs. Changes on a and b during SUB or DONE have no effect.
- Invalid state encoding: forced to IDLE on the next edge.

Test Plan:
- WIDTH=8, a=100, b=37, en pulsed high 1 cycle -> busy high for 8 cycles; then done=1, out=8'd63, borrow=0. en low in DONE -> IDLE on the next edge, out stays 63.
- a=5, b=9 -> out=8'hFC, borrow=1. a=8'h00, b=8'hFF -> out=8'h01, borrow=1.
- a=b=8'h80 -> out=0, borrow=0. a=8'hFF, b=0 -> out=8'hFF, borrow=0.
- en held high continuously from start -> state stays in DONE with done=1, and no second operation starts. Drop en for 1 cycle, then raise it with a=10, b=3 -> second result out=7, done again WIDTH+1 edges later.
- Change a and b every cycle during SUB -> result still matches the operands sampled at the start edge.
- Assert rst at the 4th SUB cycle, release, then keep en low -> out=0, borrow=0, busy=0, done=0, state IDLE. A subsequent start completes normally.

Source files
------------

// File: rtl/sub_serial.sv
// Bit-serial two's-complement subtractor: out = a - b, LSB first, one bit per clock.
// Level-enable start/done handshake shared with the serial adder.
module sub_serial #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] out,
  output logic             borrow,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [CNT_W-1:0] count;
  logic             brw;
  logic             d;
  logic             brw_next;

  always_comb begin
    d        = a_reg[0] ^ b_reg[0] ^ brw;
    brw_next = (~a_reg[0] & b_reg[0]) | (~a_reg[0] & brw) | (b_reg[0] & brw);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      a_reg  <= '0;
      b_reg  <= '0;
      count  <= '0;
      brw    <= 1'b0;
      out    <= '0;
      borrow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (en) begin
            a_reg  <= a;
            b_reg  <= b;
            out    <= '0;
            count  <= '0;
            brw    <= 1'b0;
            borrow <= 1'b0;
            state  <= SUB;
          end
        end
        SUB: begin
          // Difference bits enter at the MSB so the first bit ends at bit 0.
          out   <= {d, out[WIDTH-1:1]};
          a_reg <= a_reg >> 1;
          b_reg <= b_reg >> 1;
          brw   <= brw_next;
          count <= count + 1'b1;
          if (count == CNT_W'(WIDTH - 1)) begin
            borrow <= brw_next;
            state  <= DONE;
          end
        end
        DONE: begin
          if (!en) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == SUB);
  assign done = (state == DONE);

endmodule
